// File: rtl/interconn_recv_port.sv
// Receive endpoint for one MVU: buffers interconnect beats in a small FIFO and drains
// them into the data-memory write port. Optional source check: INTERCONN_RECV_SRCCHK_EN.
module interconn_recv_port #(
   parameter int N     = 8,
   parameter int W     = 64,
   parameter int BADDR = 15,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic [N-1:0]               recv_from,
   input  logic                       recv_en,
   input  logic [BADDR-1:0]           recv_addr,
   input  logic [W-1:0]               recv_word,
   input  logic                       mem_busy,
   input  logic                       ovf_clr,
   output logic                       mem_we,
   output logic [BADDR-1:0]           mem_addr,
   output logic [W-1:0]               mem_wdata,
   output logic [N-1:0]               mem_from,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       ovf,
   output logic [7:0]                 drop_cnt,
   output logic                       err_src
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = N + BADDR + W;

   logic [EW-1:0] fifo [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [EW-1:0] head;
   logic          src_ok, beat, full, push, pop, drop;

`ifdef INTERCONN_RECV_SRCCHK_EN
   assign src_ok = $onehot(recv_from);
`else
   assign src_ok = 1'b1;
`endif

   assign beat = recv_en && src_ok;
   assign full = (count == CW'(DEPTH));
   assign pop  = (count != '0) && !mem_busy;
   // A full FIFO still accepts a beat when the head leaves on the same edge.
   assign push = beat && (!full || pop);
   assign drop = beat && full && !pop;
   assign head = fifo[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         fifo[wr_ptr] <= {recv_from, recv_addr, recv_word};
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_from  <= '0;
         ovf       <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         mem_we <= pop;
         if (pop) begin
            {mem_from, mem_addr, mem_wdata} <= head;
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A drop on the same edge as a clear restarts the count at one.
         if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr)
               drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)
               drop_cnt <= drop_cnt + 1'b1;
         end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

`ifdef INTERCONN_RECV_SRCCHK_EN
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)
         err_src <= 1'b0;
      else if (recv_en && !src_ok)
         err_src <= 1'b1;
      else if (ovf_clr)
         err_src <= 1'b0;
   end
`else
   assign err_src = 1'b0;
`endif

endmodule

// File: tb/tb_interconn_recv_port.sv
// Directed bench for interconn_recv_port; expectations are hand-computed per step.
module tb_interconn_recv_port;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [7:0]  recv_from;
   logic        recv_en;
   logic [14:0] recv_addr;
   logic [63:0] recv_word;
   logic        mem_busy;
   logic        ovf_clr;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_from;
   logic [2:0]  count;
   logic        ovf;
   logic [7:0]  drop_cnt;
   logic        err_src;

   int checks = 0;
   int errors = 0;

   interconn_recv_port #(.N(8), .W(64), .BADDR(15), .DEPTH(4)) dut (
      .clk(clk), .clr_n(clr_n), .recv_from(recv_from), .recv_en(recv_en),
      .recv_addr(recv_addr), .recv_word(recv_word), .mem_busy(mem_busy),
      .ovf_clr(ovf_clr), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_from(mem_from), .count(count), .ovf(ovf),
      .drop_cnt(drop_cnt), .err_src(err_src)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] from, input logic [14:0] addr, input logic [63:0] word);
      recv_en   = 1'b1;
      recv_from = from;
      recv_addr = addr;
      recv_word = word;
   endtask

   initial begin
      clr_n = 1'b0; recv_en = 1'b0; recv_from = '0; recv_addr = '0; recv_word = '0;
      mem_busy = 1'b0; ovf_clr = 1'b0;
      #2;
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_err", 64'(err_src), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      #1;
      clr_n = 1'b1;

      // single beat, accepted on the first edge after reset release
      beat(8'h04, 15'h0003, 64'hdeadbeefdeadbeef);
      step();
      recv_en = 1'b0;
      chk("single_count1", 64'(count), 64'd1);
      chk("single_we0", 64'(mem_we), 64'd0);
      step();
      chk("single_we", 64'(mem_we), 64'd1);
      chk("single_addr", 64'(mem_addr), 64'h3);
      chk("single_data", mem_wdata, 64'hdeadbeefdeadbeef);
      chk("single_from", 64'(mem_from), 64'h04);
      chk("single_count0", 64'(count), 64'd0);
      step();
      chk("single_we_off", 64'(mem_we), 64'd0);

      // stall: three beats under busy, then drain in order
      mem_busy = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         beat(8'h01, 15'(i), 64'h100 + 64'(i));
         step();
         chk("stall_we", 64'(mem_we), 64'd0);
      end
      recv_en = 1'b0;
      chk("stall_count", 64'(count), 64'd3);
      step();
      chk("stall_hold_count", 64'(count), 64'd3);
      chk("stall_hold_we", 64'(mem_we), 64'd0);
      mem_busy = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("stall_drain_we", 64'(mem_we), 64'd1);
         chk("stall_drain_addr", 64'(mem_addr), 64'(i));
         chk("stall_drain_data", mem_wdata, 64'h100 + 64'(i));
         chk("stall_drain_count", 64'(count), 64'(3 - i));
      end
      step();
      chk("stall_done_we", 64'(mem_we), 64'd0);

      // overflow: five beats into a busy four-entry FIFO
      mem_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         beat(8'h02, 15'(10 + i), 64'h200 + 64'(i));
         step();
      end
      recv_en = 1'b0;
      chk("ovf_count", 64'(count), 64'd4);
      chk("ovf_flag", 64'(ovf), 64'd1);
      chk("ovf_drop", 64'(drop_cnt), 64'd1);
      mem_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ovf_drain_we", 64'(mem_we), 64'd1);
         chk("ovf_drain_addr", 64'(mem_addr), 64'(10 + i));
      end
      step();
      chk("ovf_tail_we", 64'(mem_we), 64'd0);
      chk("ovf_tail_addr", 64'(mem_addr), 64'd13);
      chk("ovf_tail_count", 64'(count), 64'd0);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr_flag", 64'(ovf), 64'd0);
      chk("ovf_clr_drop", 64'(drop_cnt), 64'd0);

      // full with simultaneous push and pop
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         beat(8'h08, 15'(20 + i), 64'h300 + 64'(i));
         step();
      end
      chk("full_count", 64'(count), 64'd4);
      mem_busy = 1'b0;
      beat(8'h10, 15'd24, 64'h304);
      step();
      recv_en = 1'b0;
      chk("full_pp_count", 64'(count), 64'd4);
      chk("full_pp_ovf", 64'(ovf), 64'd0);
      chk("full_pp_addr", 64'(mem_addr), 64'd20);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("full_drain_we", 64'(mem_we), 64'd1);
         chk("full_drain_addr", 64'(mem_addr), 64'(20 + i));
      end
      chk("full_new_data", mem_wdata, 64'h304);
      chk("full_new_from", 64'(mem_from), 64'h10);
      step();
      chk("full_done_we", 64'(mem_we), 64'd0);

      // drop counter saturation, then drop coinciding with clear
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         beat(8'h20, 15'(30 + i), 64'h400 + 64'(i));
         step();
      end
      for (int i = 0; i < 260; i++) step();
      chk("sat_drop", 64'(drop_cnt), 64'd255);
      chk("sat_count", 64'(count), 64'd4);
      ovf_clr = 1'b1;
      step();
      chk("clr_drop_ovf", 64'(ovf), 64'd1);
      chk("clr_drop_cnt", 64'(drop_cnt), 64'd1);
      recv_en = 1'b0;
      step();
      ovf_clr = 1'b0;
      chk("clr_only_ovf", 64'(ovf), 64'd0);
      chk("clr_only_cnt", 64'(drop_cnt), 64'd0);

      // reset mid-drain with three entries left
      mem_busy = 1'b0;
      step();
      chk("mid_we", 64'(mem_we), 64'd1);
      chk("mid_addr", 64'(mem_addr), 64'd30);
      chk("mid_count", 64'(count), 64'd3);
      #2;
      clr_n = 1'b0;
      #1;
      chk("mid_rst_we", 64'(mem_we), 64'd0);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_ovf", 64'(ovf), 64'd0);
      chk("mid_rst_addr", 64'(mem_addr), 64'd0);
      clr_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_we", 64'(mem_we), 64'd0);
         chk("post_rst_count", 64'(count), 64'd0);
      end

      // source check with a two-hot source
      beat(8'h03, 15'h0055, 64'h5555);
      step();
      recv_en = 1'b0;
`ifdef INTERCONN_RECV_SRCCHK_EN
      chk("src_count", 64'(count), 64'd0);
      chk("src_err", 64'(err_src), 64'd1);
      step();
      chk("src_we", 64'(mem_we), 64'd0);
      chk("src_drop", 64'(drop_cnt), 64'd0);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("src_err_clr", 64'(err_src), 64'd0);
`else
      chk("src_count", 64'(count), 64'd1);
      chk("src_err", 64'(err_src), 64'd0);
      step();
      chk("src_we", 64'(mem_we), 64'd1);
      chk("src_addr", 64'(mem_addr), 64'h55);
      chk("src_from", 64'(mem_from), 64'h03);
      chk("src_err_after", 64'(err_src), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
